// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with first-word-fall-through read data,
// occupancy count, programmable level flags and sticky error flags.
module sync_fifo_param #(
    parameter int DWIDTH    = 8,
    parameter int AWIDTH    = 3,
    parameter int AF_THRESH = 2**AWIDTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              clr_err,
    output logic [DWIDTH-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2**AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(AF_THRESH);
    localparam logic [AWIDTH:0] AE_C    = (AWIDTH+1)'(AE_THRESH);

    logic [DWIDTH-1:0] ram [DEPTH];
    logic [AWIDTH-1:0] waddr;
    logic [AWIDTH-1:0] raddr;
    logic [AWIDTH:0]   count_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              wr_acc;
    logic              rd_acc;

    // All level flags decode from the single count register.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A push into a full FIFO is legal only if a pop frees the head slot.
    assign rd_acc = rd & ~empty;
    assign wr_acc = wr & (~full | rd_acc);

    assign rdata = ram[raddr];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            ram[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waddr       <= '0;
            raddr       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                waddr <= waddr + 1'b1;
            end
            if (rd_acc) begin
                raddr <= raddr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A fresh error in the clearing cycle keeps the flag set.
            overflow_q  <= (overflow_q  & ~clr_err) | (wr & ~wr_acc);
            underflow_q <= (underflow_q & ~clr_err) | (rd & empty);
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at DWIDTH=8, AWIDTH=3.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       clr_err = 1'b0;
    logic [7:0] rdata;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int tests = 0;
    int fails = 0;

    sync_fifo_param #(.DWIDTH(8), .AWIDTH(3)) dut (
        .clk(clk),
        .rst(rst),
        .wr(wr),
        .rd(rd),
        .wdata(wdata),
        .clr_err(clr_err),
        .rdata(rdata),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr = 1'b0;
        rd = 1'b0;
        clr_err = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        idle();
        step();
        tests++;
        if (count !== 4'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
        tests++;
        if (empty !== 1'b1 || almost_empty !== 1'b1) begin
            fails++; $display("FAIL reset_empty got empty=%b ae=%b exp 1/1", empty, almost_empty);
        end
        tests++;
        if (full !== 1'b0 || almost_full !== 1'b0) begin
            fails++; $display("FAIL reset_full got full=%b af=%b exp 0/0", full, almost_full);
        end
        tests++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            fails++; $display("FAIL reset_err got ovf=%b udf=%b exp 0/0", overflow, underflow);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1;
            wdata = 8'h10 + 8'(i);
            step();
            tests++;
            if (count !== 4'(i + 1)) begin fails++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
            tests++;
            if (almost_full !== (i >= 6) || full !== (i == 7)) begin
                fails++; $display("FAIL fill_flags push=%0d got af=%b full=%b exp af=%b full=%b",
                                  i + 1, almost_full, full, i >= 6, i == 7);
            end
            tests++;
            if (almost_empty !== (i == 0)) begin
                fails++; $display("FAIL fill_ae push=%0d got=%b exp=%b", i + 1, almost_empty, i == 0);
            end
        end
        wdata = 8'h18;
        step();
        wr = 1'b0;
        tests++;
        if (count !== 4'd8 || overflow !== 1'b1) begin
            fails++; $display("FAIL overflow_push got count=%0d ovf=%b exp 8/1", count, overflow);
        end
        tests++;
        if (rdata !== 8'h10) begin fails++; $display("FAIL overflow_head got=%h exp=10", rdata); end
        // clear concurrent with a new rejected push keeps the flag
        wr = 1'b1;
        clr_err = 1'b1;
        step();
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_clr_collide got=%b exp=1", overflow); end
        wr = 1'b0;
        step();
        clr_err = 1'b0;
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (rdata !== 8'h10 + 8'(i)) begin
                fails++; $display("FAIL drain_data idx=%0d got=%h exp=%h", i, rdata, 8'h10 + 8'(i));
            end
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        tests++;
        if (empty !== 1'b1 || count !== 4'd0 || underflow !== 1'b0) begin
            fails++; $display("FAIL drain_end got empty=%b count=%0d udf=%b exp 1/0/0", empty, count, underflow);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_q [8];
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1;
            wdata = 8'h20 + 8'(i);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (rdata !== 8'h20 + 8'(i)) begin
                fails++; $display("FAIL full_rw_head idx=%0d got=%h exp=%h", i, rdata, 8'h20 + 8'(i));
            end
            wr = 1'b1;
            rd = 1'b1;
            wdata = 8'hAA;
            step();
            tests++;
            if (count !== 4'd8 || overflow !== 1'b0 || full !== 1'b1) begin
                fails++; $display("FAIL full_rw_state got count=%0d ovf=%b full=%b exp 8/0/1", count, overflow, full);
            end
        end
        wr = 1'b0;
        rd = 1'b0;
        exp_q = '{8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'hAA, 8'hAA, 8'hAA};
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (rdata !== exp_q[i]) begin
                fails++; $display("FAIL full_rw_drain idx=%0d got=%h exp=%h", i, rdata, exp_q[i]);
            end
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        tests++;
        if (empty !== 1'b1) begin fails++; $display("FAIL full_rw_empty got=%b exp=1", empty); end
    endtask

    task automatic test_empty_rw();
        wr = 1'b1;
        rd = 1'b1;
        wdata = 8'h55;
        step();
        idle();
        tests++;
        if (count !== 4'd1 || underflow !== 1'b1 || empty !== 1'b0) begin
            fails++; $display("FAIL empty_rw got count=%0d udf=%b empty=%b exp 1/1/0", count, underflow, empty);
        end
        tests++;
        if (rdata !== 8'h55) begin fails++; $display("FAIL empty_rw_data got=%h exp=55", rdata); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        tests++;
        if (underflow !== 1'b0) begin fails++; $display("FAIL udf_clear got=%b exp=0", underflow); end
        rd = 1'b1;
        step();
        tests++;
        if (underflow !== 1'b0 || empty !== 1'b1) begin
            fails++; $display("FAIL last_pop got udf=%b empty=%b exp 0/1", underflow, empty);
        end
        clr_err = 1'b1;
        step();
        idle();
        tests++;
        if (underflow !== 1'b1 || count !== 4'd0) begin
            fails++; $display("FAIL udf_clr_collide got udf=%b count=%0d exp 1/0", underflow, count);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            wr = 1'b1;
            wdata = 8'h60 + 8'(i);
            step();
            wr = 1'b0;
            tests++;
            if (count !== 4'd1 || rdata !== 8'h60 + 8'(i)) begin
                fails++; $display("FAIL wrap_push idx=%0d got count=%0d data=%h exp 1/%h",
                                  i, count, rdata, 8'h60 + 8'(i));
            end
            rd = 1'b1;
            step();
            rd = 1'b0;
            tests++;
            if (count !== 4'd0 || empty !== 1'b1) begin
                fails++; $display("FAIL wrap_pop idx=%0d got count=%0d empty=%b exp 0/1", i, count, empty);
            end
        end
        tests++;
        if (underflow !== 1'b0 || overflow !== 1'b0) begin
            fails++; $display("FAIL wrap_err got ovf=%b udf=%b exp 0/0", overflow, underflow);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1;
            wdata = 8'h70 + 8'(i);
            step();
        end
        tests++;
        if (count !== 4'd5) begin fails++; $display("FAIL pre_reset_count got=%0d exp=5", count); end
        rst = 1'b1;
        wr = 1'b1;
        wdata = 8'h99;
        step();
        idle();
        tests++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            fails++; $display("FAIL mid_reset got count=%0d empty=%b exp 0/1", count, empty);
        end
        wr = 1'b1;
        wdata = 8'h3C;
        step();
        wr = 1'b0;
        tests++;
        if (rdata !== 8'h3C || count !== 4'd1) begin
            fails++; $display("FAIL post_reset_push got data=%h count=%0d exp 3c/1", rdata, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO with data width and depth set at instantiation. It adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and simultaneous push/pop when full. It sits between the counter's command/UART paths and their consumers, anywhere the fixed 8-entry byte FIFO is too small or needs level flags. Read data is first-word-fall-through: `rdata` always presents the head entry.

## Interface
Parameters:
- `DWIDTH`, 8, data width in bits (≥1)
- `AWIDTH`, 3, address width; depth `DEPTH = 2**AWIDTH` (AWIDTH ≥ 1)
- `AF_THRESH`, `2**AWIDTH - 1`, `almost_full` asserts when count ≥ AF_THRESH (1..DEPTH)
- `AE_THRESH`, 1, `almost_empty` asserts when count ≤ AE_THRESH (0..DEPTH-1)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `wr`  in  1  push request
- `rd`  in  1  pop request
- `wdata`  in  DWIDTH  push data
- `clr_err`  in  1  clears sticky error flags
- `rdata`  out  DWIDTH  head entry (combinational from storage); valid only while `empty`=0
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `almost_full`  out  1  count ≥ AF_THRESH
- `almost_empty`  out  1  count ≤ AE_THRESH
- `count`  out  AWIDTH+1  occupancy, 0..DEPTH
- `overflow`  out  1  sticky: a push was rejected
- `underflow`  out  1  sticky: a pop was rejected

## Operation
- State registers: `waddr`, `raddr` (AWIDTH bits, wrap modulo DEPTH) and `count` (AWIDTH+1 bits). All flags decode from `count`; there are no separate full/empty registers.
- `rd_acc = rd & ~empty`.
- `wr_acc = wr & (~full | rd_acc)`. A push is accepted when the FIFO is full only if a pop is accepted in the same cycle.
- Accepted push: `ram[waddr] <= wdata`, `waddr <= waddr+1`.
- Accepted pop: `raddr <= raddr+1`.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full with wr&rd: both accepted, count stays DEPTH, no overflow. The write lands in the slot being read, and `rdata` shows the old head until the edge.
- Empty with wr&rd: push accepted, pop rejected, `underflow` set, count becomes 1.
- `wr & ~wr_acc` sets `overflow`. `rd & empty` sets `underflow`. Both flags are sticky.
- `clr_err` clears both flags. A new error in the same cycle as `clr_err` wins: the flag stays set.
- Pointer wrap from DEPTH-1 to 0 is natural binary rollover. No other wrap logic.
- Storage is not reset and has no read-enable; `rdata` is `ram[raddr]` with no pipeline.

## Timing
- Reset (synchronous, evaluated at rising edge) drives waddr=0, raddr=0, count=0, overflow=0, underflow=0.
- Outputs after reset: empty=1, full=0, almost_empty=1 (AE_THRESH ≥ 0), almost_full=0, count=0. `rdata` is undefined until the first push.
- Reset takes priority over wr/rd/clr_err in the same cycle. Reset mid-operation discards contents; data is not cleared.
- Flag latency: all flags and `count` change on the edge where the push/pop is accepted. They are visible in the following cycle.
- Push-to-read latency: data pushed at edge N appears on `rdata` after edge N when the FIFO was empty (one cycle).
- No combinational path from `wr`/`rd` to any flag output. `rdata` depends only on `raddr` and storage.

## Test plan
- Reset then idle → count=0, empty=1, almost_empty=1, full=0, overflow=underflow=0.
- DWIDTH=8, AWIDTH=3: push 0x10..0x17 (8 pushes) → count=8, full=1, almost_full=1 after the 7th push. 9th push 0x18 → count stays 8, overflow=1. Pop 8 → rdata sequence 0x10..0x17, then empty=1.
- Full FIFO, wr&rd with wdata=0xAA for 3 cycles → count stays 8, no overflow, popped values are the oldest three. Later pops return 0xAA ×3 in order.
- Empty FIFO, wr&rd with wdata=0x55 → count=1, underflow=1, rdata=0x55 next cycle. Assert clr_err → underflow=0. clr_err together with rd on empty → underflow stays 1.
- Wrap: 20 cycles of alternating push/pop of incrementing data → data order preserved across pointer rollover, count toggles 1/0.
- Mid-operation reset: after 5 pushes, assert rst for 1 cycle with wr=1 → count=0, empty=1, write ignored. A subsequent push of 0x3C reads back as 0x3C.
